// File: rtl/mcs51_timer0_peri.sv
// MCS-51 Timer/Counter 0 on the SFR bus: TCON/TMOD/TL0/TH0 decode, modes 0/1/2, TF0 interrupt request.
// Reads return one cycle after the strobe; writes land at the end of the strobe cycle; no backpressure.
module mcs51_timer0_peri #(
  parameter int         PRESCALE  = 12,
  parameter logic [7:0] ADDR_TCON = 8'h88,
  parameter logic [7:0] ADDR_TMOD = 8'h89,
  parameter logic [7:0] ADDR_TL0  = 8'h8A,
  parameter logic [7:0] ADDR_TH0  = 8'h8C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sfr_addr,
  input  logic [7:0] sfr_wdata,
  input  logic       sfr_we,
  input  logic       sfr_re,
  output logic [7:0] sfr_rdata,
  output logic       sfr_rvalid,
  input  logic       t0_pin,
  input  logic       int0_pin,
  input  logic       tf0_ack,
  output logic       irq_tf0
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;
  logic          tf0, tr0;
  logic [3:0]    tmod;
  logic [7:0]    tl0, th0;
  logic          t0_s1, t0_s2, t0_hist;
  logic          int0_s1, int0_s2;

  logic       sel_tcon, sel_tmod, sel_tl0, sel_th0, hit;
  logic       tick_mc, ext_edge, run, inc, inc_eff, ovf;
  logic [7:0] tl_cnt, th_cnt, rd_mux;

  assign sel_tcon = (sfr_addr == ADDR_TCON);
  assign sel_tmod = (sfr_addr == ADDR_TMOD);
  assign sel_tl0  = (sfr_addr == ADDR_TL0);
  assign sel_th0  = (sfr_addr == ADDR_TH0);
  assign hit      = sel_tcon | sel_tmod | sel_tl0 | sel_th0;

  assign tick_mc  = (presc == PW'(PRESCALE - 1));
  assign ext_edge = t0_hist & ~t0_s2;
  assign run      = tr0 & (~tmod[3] | int0_s2);
  assign inc      = run & (tmod[2] ? ext_edge : tick_mc);
  // A CPU write to either count register swallows a coincident increment entirely.
  assign inc_eff  = inc & ~(sfr_we & (sel_tl0 | sel_th0));

  assign irq_tf0  = tf0;

  always_comb begin
    tl_cnt = tl0;
    th_cnt = th0;
    ovf    = 1'b0;
    if (inc_eff) begin
      case (tmod[1:0])
        2'd0: {ovf, th_cnt, tl_cnt[4:0]} = {1'b0, th0, tl0[4:0]} + 14'd1;
        2'd1: {ovf, th_cnt, tl_cnt}      = {1'b0, th0, tl0} + 17'd1;
        2'd2: begin
          if (tl0 == 8'hFF) begin
            ovf    = 1'b1;
            tl_cnt = th0;
          end else begin
            tl_cnt = tl0 + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    if (sel_tcon)     rd_mux = {2'b00, tf0, tr0, 4'b0000};
    else if (sel_tmod) rd_mux = {4'b0000, tmod};
    else if (sel_tl0)  rd_mux = tl0;
    else if (sel_th0)  rd_mux = th0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      tf0        <= 1'b0;
      tr0        <= 1'b0;
      tmod       <= 4'h0;
      tl0        <= 8'h00;
      th0        <= 8'h00;
      t0_s1      <= 1'b1;
      t0_s2      <= 1'b1;
      t0_hist    <= 1'b1;
      int0_s1    <= 1'b1;
      int0_s2    <= 1'b1;
      sfr_rdata  <= 8'h00;
      sfr_rvalid <= 1'b0;
    end else begin
      presc   <= tick_mc ? '0 : presc + PW'(1);
      t0_s1   <= t0_pin;
      t0_s2   <= t0_s1;
      t0_hist <= t0_s2;
      int0_s1 <= int0_pin;
      int0_s2 <= int0_s1;

      tl0 <= (sfr_we && sel_tl0) ? sfr_wdata : tl_cnt;
      th0 <= (sfr_we && sel_th0) ? sfr_wdata : th_cnt;
      if (sfr_we && sel_tmod) tmod <= sfr_wdata[3:0];
      if (sfr_we && sel_tcon) tr0  <= sfr_wdata[4];

      // Overflow set outranks both software clear paths.
      if (ovf)                     tf0 <= 1'b1;
      else if (sfr_we && sel_tcon) tf0 <= sfr_wdata[5];
      else if (tf0_ack)            tf0 <= 1'b0;

      sfr_rvalid <= sfr_re & hit;
      if (sfr_re && hit) sfr_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mcs51_timer0_peri.sv
// Directed bench for mcs51_timer0_peri: a cycle-level arithmetic model is compared every cycle,
// and literal register reads pin the expected behaviour of each mode and collision case.
module tb_mcs51_timer0_peri;

  localparam int         PRESCALE = 12;
  localparam logic [7:0] A_TCON = 8'h88, A_TMOD = 8'h89, A_TL0 = 8'h8A, A_TH0 = 8'h8C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sfr_addr = 8'h00, sfr_wdata = 8'h00;
  logic       sfr_we = 1'b0, sfr_re = 1'b0;
  logic [7:0] sfr_rdata;
  logic       sfr_rvalid;
  logic       t0_pin = 1'b1, int0_pin = 1'b0, tf0_ack = 1'b0;
  logic       irq_tf0;

  int n_cmp = 0;
  int n_bad = 0;

  mcs51_timer0_peri #(.PRESCALE(PRESCALE)) dut (
    .clk(clk), .reset(reset), .sfr_addr(sfr_addr), .sfr_wdata(sfr_wdata),
    .sfr_we(sfr_we), .sfr_re(sfr_re), .sfr_rdata(sfr_rdata), .sfr_rvalid(sfr_rvalid),
    .t0_pin(t0_pin), .int0_pin(int0_pin), .tf0_ack(tf0_ack), .irq_tf0(irq_tf0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       model_ok = 0;
  int       m_cyc;                 // clock edges since reset
  bit [7:0] m_tl, m_th, m_rdata;
  bit [3:0] m_tmod;
  bit       m_tf, m_tr, m_rvalid;
  bit [2:0] t0_smp;                // [i] = t0_pin sampled i+1 edges ago
  bit [1:0] int0_smp;

  function automatic bit is_ours(input bit [7:0] a);
    return a == A_TCON || a == A_TMOD || a == A_TL0 || a == A_TH0;
  endfunction

  function automatic bit [7:0] reg_val(input bit [7:0] a);
    if (a == A_TCON) return (m_tf ? 8'h20 : 8'h00) | (m_tr ? 8'h10 : 8'h00);
    if (a == A_TMOD) return {4'h0, m_tmod};
    if (a == A_TL0)  return m_tl;
    return m_th;
  endfunction

  always @(posedge clk) begin : model
    int  v;
    bit  tick, fall, count, ovf;
    if (reset) begin
      model_ok = 1; m_cyc = 0;
      m_tl = 0; m_th = 0; m_tmod = 0; m_tf = 0; m_tr = 0;
      m_rdata = 0; m_rvalid = 0; t0_smp = 3'b111; int0_smp = 2'b11;
    end else if (model_ok) begin
      tick  = (m_cyc % PRESCALE) == PRESCALE - 1;
      fall  = t0_smp[2] && !t0_smp[1];
      count = m_tr && (!m_tmod[3] || int0_smp[1]) && (m_tmod[2] ? fall : tick);
      if (sfr_we && (sfr_addr == A_TL0 || sfr_addr == A_TH0)) count = 0;
      m_rvalid = sfr_re && is_ours(sfr_addr);
      if (m_rvalid) m_rdata = reg_val(sfr_addr);
      ovf = 0;
      if (count) begin
        if (m_tmod[1:0] == 2'd0) begin
          v = m_th * 32 + (m_tl % 32);
          ovf = (v == 8191);
          v = (v + 1) % 8192;
          m_th = 8'(v / 32);
          m_tl = (m_tl & 8'hE0) | 8'(v % 32);
        end else if (m_tmod[1:0] == 2'd1) begin
          v = m_th * 256 + m_tl;
          ovf = (v == 65535);
          v = (v + 1) % 65536;
          m_th = 8'(v / 256);
          m_tl = 8'(v % 256);
        end else if (m_tmod[1:0] == 2'd2) begin
          ovf = (m_tl == 8'hFF);
          m_tl = ovf ? m_th : m_tl + 8'd1;
        end
      end
      if (sfr_we) begin
        if (sfr_addr == A_TL0)  m_tl = sfr_wdata;
        if (sfr_addr == A_TH0)  m_th = sfr_wdata;
        if (sfr_addr == A_TMOD) m_tmod = sfr_wdata[3:0];
        if (sfr_addr == A_TCON) m_tr = sfr_wdata[4];
      end
      if (ovf) m_tf = 1;
      else if (sfr_we && sfr_addr == A_TCON) m_tf = sfr_wdata[5];
      else if (tf0_ack) m_tf = 0;
      t0_smp   = {t0_smp[1:0], t0_pin};
      int0_smp = {int0_smp[0], int0_pin};
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc_rdata",  sfr_rdata,  m_rdata);
      check("cyc_rvalid", sfr_rvalid, m_rvalid);
      check("cyc_irq",    irq_tf0,    m_tf);
    end
  end

  // ---------------- stimulus helpers (called just after a negedge) ----------------
  task automatic wr(input bit [7:0] a, input bit [7:0] d);
    sfr_addr = a; sfr_wdata = d; sfr_we = 1'b1;
    @(negedge clk);
    sfr_we = 1'b0;
  endtask

  task automatic rd(input bit [7:0] a, input bit [7:0] exp, input string name);
    sfr_addr = a; sfr_re = 1'b1;
    @(negedge clk);
    sfr_re = 1'b0;
    check({name, "_rvalid"}, sfr_rvalid, 1);
    check(name, sfr_rdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stop just before an edge on which the prescaler ticks.
  task automatic wait_tick();
    int guard = 0;
    while ((m_cyc % PRESCALE) != PRESCALE - 1 && guard < 2 * PRESCALE) begin
      @(negedge clk);
      guard++;
    end
    check("wait_tick_timeout", guard < 2 * PRESCALE, 1);
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    check("rst_rdata", sfr_rdata, 0);
    check("rst_rvalid", sfr_rvalid, 0);
    check("rst_irq", irq_tf0, 0);
    rd(A_TCON, 8'h00, "rst_tcon");
    rd(A_TMOD, 8'h00, "rst_tmod");
    rd(A_TL0, 8'h00, "rst_tl0");
    rd(A_TH0, 8'h00, "rst_th0");

    // Mode 1 overflow: exactly two ticks in any 24-edge window.
    wr(A_TMOD, 8'h01); wr(A_TH0, 8'hFF); wr(A_TL0, 8'hFE); wr(A_TCON, 8'h10);
    idle(2 * PRESCALE);
    rd(A_TL0, 8'h00, "m1_tl0");
    rd(A_TH0, 8'h00, "m1_th0");
    rd(A_TCON, 8'h30, "m1_tcon");
    check("m1_irq", irq_tf0, 1);
    tf0_ack = 1'b1; @(negedge clk); tf0_ack = 1'b0;
    check("m1_ack_irq", irq_tf0, 0);
    wr(A_TCON, 8'h00);

    // Mode 2 auto-reload.
    wr(A_TMOD, 8'h02); wr(A_TH0, 8'h80); wr(A_TL0, 8'hFF); wr(A_TCON, 8'h10);
    idle(PRESCALE);
    rd(A_TL0, 8'h80, "m2_tl0");
    rd(A_TH0, 8'h80, "m2_th0");
    check("m2_irq", irq_tf0, 1);
    wr(A_TCON, 8'h10);
    idle(100 * PRESCALE);
    check("m2_irq_mid", irq_tf0, 0);
    idle(30 * PRESCALE);
    check("m2_irq_again", irq_tf0, 1);
    wr(A_TCON, 8'h00);

    // Mode 0: TL0[7:5] survive the 13-bit wrap.
    wr(A_TMOD, 8'h00); wr(A_TH0, 8'hFF); wr(A_TL0, 8'hFF); wr(A_TCON, 8'h10);
    idle(PRESCALE);
    rd(A_TL0, 8'hE0, "m0_tl0");
    rd(A_TH0, 8'h00, "m0_th0");
    check("m0_irq", irq_tf0, 1);
    wr(A_TCON, 8'h00);

    // Counter mode with gate: blocked while int0 low.
    wr(A_TMOD, 8'h0D); wr(A_TL0, 8'h00); wr(A_TH0, 8'h00); wr(A_TCON, 8'h10);
    repeat (5) begin
      t0_pin = 1'b0; idle(4);
      t0_pin = 1'b1; idle(4);
    end
    rd(A_TL0, 8'h00, "gate_blocked");
    int0_pin = 1'b1; idle(4);
    for (int i = 1; i <= 5; i++) begin
      t0_pin = 1'b0; idle(2);
      rd(A_TL0, 8'(i - 1), "cnt_before");
      rd(A_TL0, 8'(i), "cnt_after");
      t0_pin = 1'b1; idle(4);
    end
    wr(A_TCON, 8'h00);
    int0_pin = 1'b0;

    // Write in the tick cycle wins over the increment.
    wr(A_TMOD, 8'h01); wr(A_TH0, 8'h00); wr(A_TL0, 8'h00); wr(A_TCON, 8'h10);
    wait_tick();
    wr(A_TL0, 8'h55);
    rd(A_TL0, 8'h55, "coll_tl0");
    wr(A_TCON, 8'h00);

    // tf0_ack in the overflow cycle loses to the set.
    wr(A_TH0, 8'hFF); wr(A_TL0, 8'hFF); wr(A_TCON, 8'h10);
    wait_tick();
    tf0_ack = 1'b1; @(negedge clk); tf0_ack = 1'b0;
    check("ack_coll_irq", irq_tf0, 1);
    wr(A_TCON, 8'h00);
    check("tcon_clr_irq", irq_tf0, 0);

    // Simultaneous read and write returns the pre-write value.
    wr(A_TL0, 8'hAA);
    sfr_addr = A_TL0; sfr_wdata = 8'hBB; sfr_we = 1'b1; sfr_re = 1'b1;
    @(negedge clk);
    sfr_we = 1'b0; sfr_re = 1'b0;
    check("rw_rvalid", sfr_rvalid, 1);
    check("rw_rdata", sfr_rdata, 8'hAA);
    rd(A_TL0, 8'hBB, "rw_after");
    sfr_addr = 8'h90; sfr_re = 1'b1; @(negedge clk); sfr_re = 1'b0;
    check("foreign_rvalid", sfr_rvalid, 0);
    check("foreign_rdata", sfr_rdata, 8'hBB);

    // Reset mid-count.
    wr(A_TMOD, 8'h01); wr(A_TL0, 8'h37); wr(A_TCON, 8'h30);
    check("pre_rst_irq", irq_tf0, 1);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    check("mid_rst_irq", irq_tf0, 0);
    rd(A_TCON, 8'h00, "mid_rst_tcon");
    rd(A_TMOD, 8'h00, "mid_rst_tmod");
    rd(A_TL0, 8'h00, "mid_rst_tl0");
    rd(A_TH0, 8'h00, "mid_rst_th0");
    idle(3 * PRESCALE);
    rd(A_TL0, 8'h00, "mid_rst_idle");

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
